// File: rtl/level_meter.sv
// Per-instrument level meter: frame-rate attack/decay smoothing with peak hold,
// rendered as vertical bar graphs for the HDMI overlay mixer.
module level_meter #(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int SETTLE_CYCLES    = 16,
    parameter int DECAY_STEP       = 4,
    parameter int PEAK_HOLD_FRAMES = 30,
    parameter int PEAK_FALL_STEP   = 2,
    parameter int BAR_X0           = 64,
    parameter int BAR_WIDTH        = 64,
    parameter int BAR_GAP          = 16,
    parameter int BAR_BOTTOM       = 700
) (
    input  logic                          clk_pixel,
    input  logic                          rst,
    input  logic                          new_frame,
    input  logic [8*INSTRUMENT_COUNT-1:0] max_sample_intensity,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    output logic [8*INSTRUMENT_COUNT-1:0] level,
    output logic [8*INSTRUMENT_COUNT-1:0] peak,
    output logic                          update_done,
    output logic                          bar_on,
    output logic                          peak_on,
    output logic [1:0]                    bar_index
);

    localparam int IDX_W  = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(PEAK_HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        UPDATE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               do_update;

    logic [7:0]         level_q [INSTRUMENT_COUNT];
    logic [7:0]         peak_q  [INSTRUMENT_COUNT];
    logic [HOLD_W-1:0]  hold_q  [INSTRUMENT_COUNT];

    logic [7:0]         in_s, lvl_s, pk_s;
    logic [HOLD_W-1:0]  hold_s;
    logic [7:0]         lvl_dec, pk_dec, lvl_n, pk_n;
    logic [HOLD_W-1:0]  hold_n;

    logic               bar_on_q, bar_on_d;
    logic               peak_on_q, peak_on_d;
    logic [1:0]         bar_idx_q, bar_idx_d;
    int                 px0, pd;

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // A new_frame in any state restarts the settle wait; it wins over an update in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        do_update = 1'b0;
        if (new_frame) begin
            state_d = WAIT;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_d = UPDATE;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                UPDATE: begin
                    do_update = 1'b1;
                    if (idx_q == IDX_W'(INSTRUMENT_COUNT - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_s   = '0;
        lvl_s  = '0;
        pk_s   = '0;
        hold_s = '0;
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
            if (idx_q == IDX_W'(i)) begin
                in_s   = max_sample_intensity[8*i +: 8];
                lvl_s  = level_q[i];
                pk_s   = peak_q[i];
                hold_s = hold_q[i];
            end
        end

        lvl_dec = (lvl_s >= 8'(DECAY_STEP)) ? lvl_s - 8'(DECAY_STEP) : 8'd0;
        pk_dec  = (pk_s >= 8'(PEAK_FALL_STEP)) ? pk_s - 8'(PEAK_FALL_STEP) : 8'd0;
        lvl_n   = (in_s > lvl_dec) ? in_s : lvl_dec;

        // Falling peak never drops below the new level, keeping peak >= level.
        if (in_s >= pk_s) begin
            pk_n   = in_s;
            hold_n = HOLD_W'(PEAK_HOLD_FRAMES);
        end else if (hold_s != '0) begin
            pk_n   = pk_s;
            hold_n = hold_s - 1'b1;
        end else begin
            pk_n   = (lvl_n > pk_dec) ? lvl_n : pk_dec;
            hold_n = hold_s;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                level_q[i] <= '0;
                peak_q[i]  <= '0;
                hold_q[i]  <= '0;
            end
        end else if (do_update) begin
            for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    level_q[i] <= lvl_n;
                    peak_q[i]  <= pk_n;
                    hold_q[i]  <= hold_n;
                end
            end
        end
    end

    // Pixel path reads live registers, so a bar may change mid-scan during an update.
    always_comb begin
        bar_on_d  = 1'b0;
        peak_on_d = 1'b0;
        bar_idx_d = 2'd0;
        px0       = 0;
        pd        = BAR_BOTTOM - int'(vcount);
        for (int i = 0; i < INSTRUMENT_COUNT; i++) begin
            px0 = BAR_X0 + i * (BAR_WIDTH + BAR_GAP);
            if (int'(hcount) >= px0 && int'(hcount) < px0 + BAR_WIDTH) begin
                bar_idx_d = 2'(i);
                if (int'(vcount) <= BAR_BOTTOM) begin
                    bar_on_d  = pd < int'(level_q[i]);
                    peak_on_d = (peak_q[i] != 8'd0) && (pd == int'(peak_q[i]) - 1);
                end
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (rst) begin
            bar_on_q  <= 1'b0;
            peak_on_q <= 1'b0;
            bar_idx_q <= 2'd0;
        end else begin
            bar_on_q  <= bar_on_d;
            peak_on_q <= peak_on_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    for (genvar g = 0; g < INSTRUMENT_COUNT; g++) begin : g_pack
        assign level[8*g +: 8] = level_q[g];
        assign peak[8*g +: 8]  = peak_q[g];
    end

    assign update_done = done_q;
    assign bar_on      = bar_on_q;
    assign peak_on     = peak_on_q;
    assign bar_index   = bar_idx_q;

endmodule

// File: tb/tb_level_meter.sv
// Scoreboard bench for level_meter: stimulus pushes expected frame results and
// pixel responses; a monitor pops and compares when the DUT presents them.
module tb_level_meter;

    logic        clk_pixel = 1'b0;
    logic        rst;
    logic        new_frame;
    logic [23:0] max_sample_intensity;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] level;
    logic [23:0] peak;
    logic        update_done;
    logic        bar_on;
    logic        peak_on;
    logic [1:0]  bar_index;

    level_meter dut (
        .clk_pixel            (clk_pixel),
        .rst                  (rst),
        .new_frame            (new_frame),
        .max_sample_intensity (max_sample_intensity),
        .hcount               (hcount),
        .vcount               (vcount),
        .level                (level),
        .peak                 (peak),
        .update_done          (update_done),
        .bar_on               (bar_on),
        .peak_on              (peak_on),
        .bar_index            (bar_index)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        int          doneCycle;
        logic [23:0] lvl;
        logic [23:0] pk;
        string       tag;
    } frameExp_t;

    typedef struct {
        int          cyc;
        logic        b;
        logic        p;
        logic [1:0]  idx;
        string       tag;
    } pixExp_t;

    frameExp_t frameQ[$];
    pixExp_t   pixQ[$];
    frameExp_t fe;
    pixExp_t   pe;

    int cycleCount = 0;
    int compared   = 0;
    int mismatched = 0;

    always @(posedge clk_pixel) cycleCount <= cycleCount + 1;

    function automatic logic [23:0] pack3(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: frame results on update_done, pixel results at their due cycle.
    always @(negedge clk_pixel) begin
        if (rst === 1'b0 && update_done === 1'b1) begin
            if (frameQ.size() == 0) begin
                checkOutput("unexpected update_done", 32'(update_done), 32'd0);
            end else begin
                fe = frameQ.pop_front();
                checkOutput({fe.tag, " done cycle"}, cycleCount, fe.doneCycle);
                checkOutput({fe.tag, " level"}, 32'(level), 32'(fe.lvl));
                checkOutput({fe.tag, " peak"}, 32'(peak), 32'(fe.pk));
            end
        end
        if (pixQ.size() > 0 && pixQ[0].cyc == cycleCount) begin
            pe = pixQ.pop_front();
            checkOutput(pe.tag, 32'({bar_on, peak_on, bar_index}), 32'({pe.b, pe.p, pe.idx}));
        end
    end

    task automatic waitDone(input string tag);
        int t;
        t = 0;
        while (frameQ.size() != 0 && t < 100) begin
            @(negedge clk_pixel);
            t++;
        end
        if (frameQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s timeout: got no update_done, expected one", tag);
            frameQ.delete();
        end
    endtask

    task automatic applyStimulus(input logic [23:0] inVec, input logic [23:0] expL,
                                 input logic [23:0] expP, input string tag);
        frameExp_t e;
        @(negedge clk_pixel);
        max_sample_intensity = inVec;
        new_frame            = 1'b1;
        e.doneCycle = cycleCount + 20;
        e.lvl       = expL;
        e.pk        = expP;
        e.tag       = tag;
        frameQ.push_back(e);
        @(negedge clk_pixel);
        new_frame = 1'b0;
        waitDone(tag);
    endtask

    task automatic applyPixel(input int h, input int v, input logic b, input logic p,
                              input logic [1:0] idx);
        pixExp_t e;
        @(negedge clk_pixel);
        hcount = 11'(h);
        vcount = 10'(v);
        e.cyc  = cycleCount + 1;
        e.b    = b;
        e.p    = p;
        e.idx  = idx;
        e.tag  = $sformatf("pixel h=%0d v=%0d", h, v);
        pixQ.push_back(e);
    endtask

    initial begin
        int l0, l2, p0, p2;
        frameExp_t e;

        rst                  = 1'b1;
        new_frame            = 1'b0;
        max_sample_intensity = '0;
        hcount               = 11'd64;
        vcount               = 10'd700;
        repeat (3) @(negedge clk_pixel);
        checkOutput("reset level", 32'(level), 32'd0);
        checkOutput("reset peak", 32'(peak), 32'd0);
        checkOutput("reset update_done", 32'(update_done), 32'd0);
        checkOutput("reset pixel outputs", 32'({bar_on, peak_on, bar_index}), 32'd0);
        rst = 1'b0;

        // First frame, then 55 frames of silence: hold, fall and decay saturation.
        applyStimulus(pack3(200, 0, 255), pack3(200, 0, 255), pack3(200, 0, 255), "frame0");
        for (int k = 1; k <= 55; k++) begin
            l0 = 200 - 4 * k;
            if (l0 < 0) l0 = 0;
            l2 = 255 - 4 * k;
            if (l2 < 0) l2 = 0;
            p0 = (k <= 30) ? 200 : 200 - 2 * (k - 30);
            p2 = (k <= 30) ? 255 : 255 - 2 * (k - 30);
            applyStimulus(pack3(0, 0, 0), pack3(l0, 0, l2), pack3(p0, 0, p2),
                          $sformatf("decay frame %0d", k));
        end

        // Attack beats decay; decay below zero saturates.
        @(negedge clk_pixel);
        rst = 1'b1;
        @(negedge clk_pixel);
        rst = 1'b0;
        applyStimulus(pack3(2, 2, 9), pack3(2, 2, 9), pack3(2, 2, 9), "attack A");
        applyStimulus(pack3(3, 3, 3), pack3(3, 3, 5), pack3(3, 3, 9), "attack B");
        applyStimulus(pack3(0, 0, 1), pack3(0, 0, 1), pack3(3, 3, 9), "decay floor");

        // Second new_frame mid-WAIT: only the restarted frame may complete.
        @(negedge clk_pixel);
        max_sample_intensity = pack3(50, 60, 70);
        new_frame            = 1'b1;
        @(negedge clk_pixel);
        new_frame = 1'b0;
        repeat (4) @(negedge clk_pixel);
        new_frame   = 1'b1;
        e.doneCycle = cycleCount + 20;
        e.lvl       = pack3(50, 60, 70);
        e.pk        = pack3(50, 60, 70);
        e.tag       = "restart";
        frameQ.push_back(e);
        @(negedge clk_pixel);
        new_frame = 1'b0;
        waitDone("restart");

        // Reset during UPDATE after instrument 0 is written: no done pulse follows.
        @(negedge clk_pixel);
        max_sample_intensity = pack3(99, 99, 99);
        new_frame            = 1'b1;
        @(negedge clk_pixel);
        new_frame = 1'b0;
        repeat (17) @(negedge clk_pixel);
        checkOutput("mid-update level", 32'(level), 32'(pack3(99, 60, 70)));
        rst = 1'b1;
        @(negedge clk_pixel);
        rst = 1'b0;
        checkOutput("mid-update reset level", 32'(level), 32'd0);
        checkOutput("mid-update reset peak", 32'(peak), 32'd0);
        repeat (25) @(negedge clk_pixel);

        // Build level0=10/peak0=20, level2=peak2=100 for the pixel sweep.
        applyStimulus(pack3(20, 0, 100), pack3(20, 0, 100), pack3(20, 0, 100), "pix setup 1");
        applyStimulus(pack3(0, 0, 100), pack3(16, 0, 100), pack3(20, 0, 100), "pix setup 2");
        applyStimulus(pack3(0, 0, 100), pack3(12, 0, 100), pack3(20, 0, 100), "pix setup 3");
        applyStimulus(pack3(10, 0, 100), pack3(10, 0, 100), pack3(20, 0, 100), "pix setup 4");

        for (int v = 670; v <= 705; v++)
            applyPixel(64, v, (v >= 691 && v <= 700), (v == 681), 2'd0);
        for (int v = 678; v <= 700; v++)
            applyPixel(128, v, 1'b0, 1'b0, 2'd0);
        applyPixel(127, 700, 1'b1, 1'b0, 2'd0);
        applyPixel(63, 700, 1'b0, 1'b0, 2'd0);
        applyPixel(144, 700, 1'b0, 1'b0, 2'd1);
        applyPixel(230, 700, 1'b1, 1'b0, 2'd2);
        applyPixel(230, 601, 1'b1, 1'b1, 2'd2);
        applyPixel(230, 600, 1'b0, 1'b0, 2'd2);
        applyPixel(230, 701, 1'b0, 1'b0, 2'd2);
        applyPixel(287, 700, 1'b1, 1'b0, 2'd2);
        applyPixel(288, 700, 1'b0, 1'b0, 2'd0);
        repeat (3) @(negedge clk_pixel);
        if (pixQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL pixel queue: got %0d unchecked, expected 0", pixQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/level_meter.md
Name: level_meter

Overview:
- Consumes the per-instrument frame-peak intensities from the note tracker on clk_pixel.
- Applies frame-rate attack/decay smoothing and a peak-hold marker per instrument.
- Renders the results as vertical bar graphs from pixel coordinates, for the HDMI overlay mixer.
- All logic runs on a single clock domain (clk_pixel).

Parameters:
- INSTRUMENT_COUNT, 3, number of instrument bars.
- SETTLE_CYCLES, 16, clk_pixel cycles waited after new_frame before sampling inputs. Must be >= 9, to cover the tracker's output update delay.
- DECAY_STEP, 4, level decrement per frame when the input is below the level.
- PEAK_HOLD_FRAMES, 30, frames the peak marker holds before falling.
- PEAK_FALL_STEP, 2, peak decrement per frame after the hold expires.
- BAR_X0, 64, hcount of the left edge of bar 0.
- BAR_WIDTH, 64, bar width in pixels.
- BAR_GAP, 16, horizontal gap between bars.
- BAR_BOTTOM, 700, vcount of the bottom bar row (level 1 lights this row only).

Ports:
- clk_pixel  input  1  pixel clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- new_frame  input  1  single-cycle pulse at frame start.
- max_sample_intensity  input  8 x INSTRUMENT_COUNT  per-instrument frame peak, 0..255.
- hcount  input  11  current pixel x.
- vcount  input  10  current pixel y.
- level  output  8 x INSTRUMENT_COUNT  smoothed level per instrument.
- peak  output  8 x INSTRUMENT_COUNT  peak-hold value per instrument.
- update_done  output  1  one-cycle pulse when all instruments have been updated for a frame.
- bar_on  output  1  current pixel lies inside a lit bar region.
- peak_on  output  1  current pixel lies on a peak-marker row.
- bar_index  output  2  index of the bar containing hcount; 0 when none.

Behaviour:
- Reset (synchronous, active-high): all levels, peaks and hold counters = 0; state = IDLE; update_done, bar_on, peak_on, bar_index = 0.
- FSM states:
  - IDLE: new_frame -> WAIT, settle counter = 0.
  - WAIT: counter increments each cycle. When counter == SETTLE_CYCLES-1 -> UPDATE, index = 0.
  - UPDATE: processes instrument[index] in one cycle, then index++. After index == INSTRUMENT_COUNT-1 -> IDLE, and update_done pulses on the cycle after that last update.
- new_frame arriving in WAIT or UPDATE: restart WAIT with counter = 0 and index = 0. Instruments already updated keep their new values; the remaining ones are not updated for the aborted frame.
- Level update, with in = max_sample_intensity[index] sampled in UPDATE:
  - lvl_n = max(in, sat_sub(level, DECAY_STEP)).
  - sat_sub floors at 0; no wrap.
- Peak update, in priority order:
  1. in >= peak: peak <= in, hold <= PEAK_HOLD_FRAMES.
  2. else hold != 0: hold decrements; peak unchanged.
  3. else: peak <= max(lvl_n, sat_sub(peak, PEAK_FALL_STEP)).
- Invariant: peak >= level at all times.
- Pixel path: registered, 1-cycle latency from hcount/vcount to bar_on, peak_on and bar_index.
  - Bar i spans hcount in [BAR_X0 + i*(BAR_WIDTH+BAR_GAP), that value + BAR_WIDTH).
  - d = BAR_BOTTOM - vcount, valid only when vcount <= BAR_BOTTOM.
  - bar_on = inside bar i AND vcount <= BAR_BOTTOM AND d < level[i].
  - peak_on = inside bar i AND vcount <= BAR_BOTTOM AND peak[i] != 0 AND d == peak[i]-1.
  - Outside every bar, or vcount > BAR_BOTTOM: bar_on = peak_on = 0.
- Pixel path reads the current level/peak registers; the mid-frame update glitch is accepted.
- Reset mid-UPDATE: all state cleared on the next edge; no update_done pulse.

Test Plan:
- Reset, then new_frame with inputs {200,0,255} -> update_done pulses 16+3 cycles later. level = {200,0,255}; peak = {200,0,255}.
- Hold inputs at 0 for 10 frames after level 200 -> level 160 (200-10*4); peak stays 200 (hold active).
- Inputs at 0 for 31 frames from peak 200 / level 200:
  - Frames 1-30: hold counts down, peak stays 200.
  - Frame 31: peak = 198.
  - Level saturates at 0 after 50 frames and never wraps.
- Level 2 at input 3 -> level 3 (attack wins). Level 3, DECAY_STEP 4, input 0 -> level 0.
- Second new_frame 5 cycles into WAIT -> WAIT restarts. update_done occurs 16+3 cycles after the second pulse only.
- level[0] = 10, peak[0] = 20; sweep bar 0 at hcount 64, then hcount 128:
  - At hcount 64: bar_on high for vcount 691..700; peak_on high only at vcount 681, one cycle after the coordinates are presented.
  - At hcount 128: bar_on = 0 (gap).
